// File: rtl/dram_responder.sv
// dram_responder: handshake data-memory slave for the core's MEM stage.
//
// It accepts one word-addressed load/store at a time. A request is
// accepted while IDLE. A store commits its byte lanes to the RAM on the
// acceptance edge. A load captures the RAM word into the response
// register on that same edge. After WAIT_CYCLES wait states the response
// is offered through a valid/ready handshake.
//
// Parameters:
//   ADDR_W      - word address width
//   DEPTH_WORDS - number of 32-bit words (power of two, <= 2**ADDR_W)
//   WAIT_CYCLES - extra cycles between acceptance and response (0..7)
//
// Ports:
//   clk, rst              - clock; synchronous active-high reset
//   req_valid / req_ready - request handshake
//   req_addr              - word address
//   req_wstrb             - byte write strobes (0 = read)
//   req_wdata             - store data, lanes already aligned
//   rsp_valid / rsp_ready - response handshake
//   rsp_rdata             - load data (0 for stores)
//   rsp_err               - out-of-range access
//
// Optional build macro:
//   DRAM_RANGE_CHK_EN - when it is defined, an address >= DEPTH_WORDS
//                       returns rsp_err=1 and does not touch the RAM.
//                       When it is not defined, the address wraps modulo
//                       DEPTH_WORDS and rsp_err is always 0.
module dram_responder #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_wstrb,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [1:0]       state;
  logic [2:0]       wait_cnt;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             accept;
  logic             is_write;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  assign idx      = req_addr[IDX_W-1:0];
  assign is_write = |req_wstrb;

`ifdef DRAM_RANGE_CHK_EN
  // Any address bit at or above IDX_W makes the access out of range.
  assign in_range = ((req_addr >> IDX_W) == '0);
`else
  // Without the range check, the upper address bits are simply dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr;
  assign in_range    = 1'b1;
`endif

  // rst takes priority, so a request seen in a reset cycle is never accepted.
  assign accept    = req_valid && (state == ST_IDLE) && !rst;
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // ---- acceptance edge: byte-lane RAM write (RAM contents are not reset) ----
  always_ff @(posedge clk) begin
    if (accept && is_write && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // ---- control FSM and response register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            // The RAM read happens on the acceptance edge. It sees the old
            // word, which is fine because only one request is outstanding.
            rdata_q <= (is_write || !in_range) ? 32'd0 : mem[idx];
            err_q   <= !in_range;
            if (WAIT_CYCLES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end
        ST_RESP: begin
          // rdata_q and err_q are not written here, so they stay stable
          // while the response is back-pressured.
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
module tb_dram_responder;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 16384;
  localparam int WAIT   = 1;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_wstrb;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  dram_responder #(
    .ADDR_W(ADDR_W),
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_wstrb(req_wstrb),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endfunction

  // Response monitor: pops the expected entry when rsp_valid rises.
  // It then checks the data and error on every cycle that the response is held.
  logic mon_prev_v = 1'b0;
  logic mon_have   = 1'b0;
  exp_t mon_cur;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_v = 1'b0;
        mon_have   = 1'b0;
      end else if (rsp_valid) begin
        if (!mon_prev_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            mon_have = 1'b0;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
          end else begin
            mon_cur  = exp_q.pop_front();
            mon_have = 1'b1;
            chk({mon_cur.name, "_latency"}, 32'(cyc - mon_cur.acc_cyc), 32'(WAIT + 1));
          end
        end
        if (mon_have) begin
          chk({mon_cur.name, "_rdata"}, rsp_rdata, mon_cur.rdata);
          chk({mon_cur.name, "_err"}, {31'd0, rsp_err}, {31'd0, mon_cur.err});
        end
        mon_prev_v = 1'b1;
      end else begin
        mon_prev_v = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic do_req(input logic [ADDR_W-1:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic [31:0] erd,
                        input logic eerr, input string nm);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout: got req_ready=0 expected 1", nm);
      return;
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = data;
    e.rdata   = erd;
    e.err     = eerr;
    e.acc_cyc = cyc;
    e.name    = nm;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!(req_ready && !rsp_valid && exp_q.size() == 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(req_ready && !rsp_valid && exp_q.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL %s_done_timeout: got req_ready=%0b rsp_valid=%0b pending=%0d expected idle",
               nm, req_ready, rsp_valid, exp_q.size());
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wstrb = 4'h0;
    req_wdata = 32'd0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-word write, then read back.
    do_req(16'h0010, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0, "wr10");
    wait_done("wr10");
    do_req(16'h0010, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0, "rd10");
    wait_done("rd10");

    // Partial strobes.
    do_req(16'h0004, 4'hF, 32'h11223344, 32'd0, 1'b0, "wr04a");
    wait_done("wr04a");
    do_req(16'h0004, 4'b0101, 32'hAABBCCDD, 32'd0, 1'b0, "wr04b");
    wait_done("wr04b");
    do_req(16'h0004, 4'h0, 32'd0, 32'h11BB33DD, 1'b0, "rd04");
    wait_done("rd04");

    // Backpressure. Requests that arrive while busy must be ignored.
    do_req(16'h0030, 4'hF, 32'hCAFEF00D, 32'd0, 1'b0, "wr30");
    wait_done("wr30");
    rsp_ready = 1'b0;
    do_req(16'h0030, 4'h0, 32'd0, 32'hCAFEF00D, 1'b0, "rd30_bp");
    for (int i = 0; i < WAIT + 5; i++) begin
      req_valid = 1'b1;
      req_addr  = 16'h0030;
      req_wstrb = 4'hF;
      req_wdata = 32'h0;
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_rsp_held", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    do_req(16'h0030, 4'h0, 32'd0, 32'hCAFEF00D, 1'b0, "rd30_after");
    wait_done("rd30_after");

    // Reset while a write response is pending.
    do_req(16'h0020, 4'hF, 32'h5A5A5A5A, 32'd0, 1'b0, "wr20");
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    do_req(16'h0020, 4'h0, 32'd0, 32'h5A5A5A5A, 1'b0, "rd20");
    wait_done("rd20");

    // Out-of-range address: either an error or wrap-around.
    do_req(16'h0000, 4'hF, 32'h01234567, 32'd0, 1'b0, "wr00");
    wait_done("wr00");
`ifdef DRAM_RANGE_CHK_EN
    do_req(16'h4000, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b1, "wr4000");
    wait_done("wr4000");
    do_req(16'h4000, 4'h0, 32'd0, 32'd0, 1'b1, "rd4000");
    wait_done("rd4000");
    do_req(16'h0000, 4'h0, 32'd0, 32'h01234567, 1'b0, "rd00");
    wait_done("rd00");
`else
    do_req(16'h4000, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b0, "wr4000");
    wait_done("wr4000");
    do_req(16'h0000, 4'h0, 32'd0, 32'hFFFFFFFF, 1'b0, "rd00");
    wait_done("rd00");
`endif

    repeat (5) @(negedge clk);
    chk("pending_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
